// File: rtl/de_serial_hs.sv
// Width gearbox: packs IN-bit words into OUT-bit words, LSB first, with valid/ready on both sides.
// An input word flagged last flushes the residue zero-padded and tags the final output word.
module de_serial_hs #(
  parameter int unsigned IN  = 12,
  parameter int unsigned OUT = 8,
  localparam int unsigned BUF   = IN + OUT,
  localparam int unsigned LVL_W = $clog2(IN + OUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN-1:0]    in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [OUT-1:0]   out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic [LVL_W-1:0] level
);

  localparam logic [LVL_W-1:0] OUT_L = LVL_W'(OUT);
  localparam logic [LVL_W-1:0] IN_L  = LVL_W'(IN);
  localparam logic [LVL_W-1:0] BUF_L = LVL_W'(BUF);

  logic [BUF-1:0]   acc_q, acc_d, shifted;
  logic [LVL_W-1:0] lvl_q, lvl_d, lvl_sh;
  logic             pend_q, pend_d;
  logic             pop, push;

  // Accepting only while level <= OUT keeps level + IN within BUF.
  assign in_ready  = !pend_q && (lvl_q <= OUT_L);
  assign out_valid = (lvl_q >= OUT_L) || (pend_q && (lvl_q != '0));
  assign out_last  = pend_q && (lvl_q <= OUT_L);
  assign out_data  = acc_q[OUT-1:0];
  assign level     = lvl_q;

  assign pop  = out_valid && out_ready;
  assign push = in_valid && in_ready;

  // Pop shifts first; a same-cycle push appends behind the surviving bits.
  always_comb begin
    shifted = acc_q;
    lvl_sh  = lvl_q;
    pend_d  = pend_q;
    if (pop) begin
      shifted = acc_q >> OUT;
      lvl_sh  = (lvl_q >= OUT_L) ? (lvl_q - OUT_L) : '0;
      if (out_last) pend_d = 1'b0;
    end
    acc_d = shifted;
    lvl_d = lvl_sh;
    if (push) begin
      acc_d = shifted | (BUF'(in_data) << lvl_sh);
      lvl_d = lvl_sh + IN_L;
      if (in_last) pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      lvl_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      lvl_q  <= lvl_d;
      pend_q <= pend_d;
    end
  end

  a_level_range: assert property (@(posedge clk) disable iff (rst) lvl_q <= BUF_L);
  a_upper_zero:  assert property (@(posedge clk) disable iff (rst) (acc_q >> lvl_q) == '0);
  a_out_hold:    assert property (@(posedge clk) disable iff (rst)
                   (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_last)));

endmodule

// File: tb/tb_de_serial_hs.sv
// Bench for de_serial_hs: three width configurations checked every cycle against a bit-queue model,
// plus directed scenarios with hand-computed output words.
module tb_de_serial_hs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  iv, il, ordy, ir, ov, ol;
  logic [15:0] idat [3];
  logic [7:0]  d0;
  logic [15:0] d1;
  logic [11:0] d2;
  logic [4:0]  lv0, lv1, lv2;

  de_serial_hs #(.IN(12), .OUT(8)) u0 (
    .clk(clk), .rst(rst), .in_data(idat[0][11:0]), .in_valid(iv[0]), .in_last(il[0]),
    .in_ready(ir[0]), .out_data(d0), .out_valid(ov[0]), .out_last(ol[0]),
    .out_ready(ordy[0]), .level(lv0));
  de_serial_hs #(.IN(4), .OUT(16)) u1 (
    .clk(clk), .rst(rst), .in_data(idat[1][3:0]), .in_valid(iv[1]), .in_last(il[1]),
    .in_ready(ir[1]), .out_data(d1), .out_valid(ov[1]), .out_last(ol[1]),
    .out_ready(ordy[1]), .level(lv1));
  de_serial_hs #(.IN(8), .OUT(12)) u2 (
    .clk(clk), .rst(rst), .in_data(idat[2][7:0]), .in_valid(iv[2]), .in_last(il[2]),
    .in_ready(ir[2]), .out_data(d2), .out_valid(ov[2]), .out_last(ol[2]),
    .out_ready(ordy[2]), .level(lv2));

  int npass = 0;
  int ntotal = 0;
  bit chk_en = 1'b0;

  bit          mq [3][$];
  bit          mpend [3];
  bit          macc [3];
  int          mpops [3];
  int          dpops [3];
  logic [16:0] obs [3][$];

  function automatic int inw(int i);
    case (i)
      0: return 12;
      1: return 4;
      default: return 8;
    endcase
  endfunction

  function automatic int outw(int i);
    case (i)
      0: return 8;
      1: return 16;
      default: return 12;
    endcase
  endfunction

  function automatic logic [15:0] od(int i);
    case (i)
      0: return 16'(d0);
      1: return d1;
      default: return 16'(d2);
    endcase
  endfunction

  function automatic int lvf(int i);
    case (i)
      0: return int'(lv0);
      1: return int'(lv1);
      default: return int'(lv2);
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    ntotal++;
    if (act == exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Model: a queue of held bits; outputs follow from its size, head and the pending-last flag.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin : mdl
      int sz;
      bit eov, eol, eir;
      macc[i] = 1'b0;
      if (rst) begin
        mq[i].delete();
        mpend[i] = 1'b0;
      end else begin
        sz  = mq[i].size();
        eov = (sz >= outw(i)) || (mpend[i] && sz > 0);
        eol = mpend[i] && (sz <= outw(i));
        eir = !mpend[i] && (sz <= outw(i));
        if (eov && ordy[i]) begin
          for (int k = 0; k < outw(i) && mq[i].size() > 0; k++) void'(mq[i].pop_front());
          mpops[i]++;
          if (eol) mpend[i] = 1'b0;
        end
        if (iv[i] && eir) begin
          for (int k = 0; k < inw(i); k++) mq[i].push_back(idat[i][k]);
          if (il[i]) mpend[i] = 1'b1;
          macc[i] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      for (int i = 0; i < 3; i++) begin : cmp
        int sz;
        bit eov;
        logic [15:0] ed;
        sz  = mq[i].size();
        eov = (sz >= outw(i)) || (mpend[i] && sz > 0);
        ed  = '0;
        for (int k = 0; k < outw(i) && k < sz; k++) ed[k] = mq[i][k];
        chk($sformatf("u%0d_level", i), lvf(i), sz);
        chk($sformatf("u%0d_in_ready", i), int'(ir[i]), int'(!mpend[i] && sz <= outw(i)));
        chk($sformatf("u%0d_out_valid", i), int'(ov[i]), int'(eov));
        if (eov) begin
          chk($sformatf("u%0d_out_data", i), int'(od(i)), int'(ed));
          chk($sformatf("u%0d_out_last", i), int'(ol[i]), int'(mpend[i] && sz <= outw(i)));
        end
        if (ov[i] && ordy[i]) begin
          obs[i].push_back({ol[i], od(i)});
          dpops[i]++;
        end
      end
    end
  end

  task automatic push(input int i, input logic [15:0] d, input logic last);
    int n;
    iv[i] = 1'b1;
    idat[i] = d;
    il[i] = last;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!macc[i] && n < 200);
    if (!macc[i]) chk($sformatf("u%0d_push_timeout", i), 0, 1);
    iv[i] = 1'b0;
    il[i] = 1'b0;
  endtask

  task automatic wait_obs(input int i, input int cnt);
    int n;
    n = 0;
    while (obs[i].size() < cnt && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (obs[i].size() < cnt) chk($sformatf("u%0d_obs_timeout", i), obs[i].size(), cnt);
  endtask

  task automatic chk_word(input int i, input int j, input string nm, input logic [16:0] exp);
    if (j < obs[i].size()) chk(nm, int'(obs[i][j]), int'(exp));
    else chk(nm, -1, int'(exp));
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    int cnt [3];
    int cyc;
    rst = 1'b1; iv = '0; il = '0; ordy = '0;
    for (int i = 0; i < 3; i++) idat[i] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    @(negedge clk);
    chk("rst_level", int'(lv0), 0);
    chk("rst_in_ready", int'(ir[0]), 1);
    chk("rst_out_valid", int'(ov[0]), 0);
    chk("rst_out_last", int'(ol[0]), 0);

    // Plain packing 12 -> 8
    @(posedge clk); #1;
    ordy[0] = 1'b1;
    obs[0].delete();
    push(0, 16'hABC, 1'b0);
    push(0, 16'hDEF, 1'b0);
    repeat (4) @(negedge clk);
    chk("t1_words", obs[0].size(), 3);
    chk_word(0, 0, "t1_w0", 17'h000BC);
    chk_word(0, 1, "t1_w1", 17'h000FA);
    chk_word(0, 2, "t1_w2", 17'h000DE);
    chk("t1_level", int'(lv0), 0);

    // Single word frame flushes a padded tail
    obs[0].delete();
    push(0, 16'hABC, 1'b1);
    @(negedge clk);
    chk("t2_ready_lo", int'(ir[0]), 0);
    wait_obs(0, 2);
    @(negedge clk);
    chk("t2_ready_hi", int'(ir[0]), 1);
    chk_word(0, 0, "t2_w0", 17'h000BC);
    chk_word(0, 1, "t2_w1", 17'h1000A);

    // Consumer backpressure holds state
    obs[0].delete();
    ordy[0] = 1'b0;
    iv[0] = 1'b1; idat[0] = 16'hABC; il[0] = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!macc[0] && cyc < 50);
    repeat (10) begin
      @(negedge clk);
      chk("t3_level", int'(lv0), 12);
      chk("t3_in_ready", int'(ir[0]), 0);
      chk("t3_out_valid", int'(ov[0]), 1);
      chk("t3_out_data", int'(d0), 'hBC);
    end
    @(posedge clk); #1 ordy[0] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t3_level_after", int'(lv0), 4);
    chk("t3_ready_after", int'(ir[0]), 1);
    iv[0] = 1'b0;
    chk_word(0, 0, "t3_w0", 17'h000BC);

    // Reset mid-frame drops held bits
    do_reset();
    ordy[0] = 1'b0;
    push(0, 16'hABC, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_level", int'(lv0), 0);
    chk("t5_out_valid", int'(ov[0]), 0);
    obs[0].delete();
    ordy[0] = 1'b1;
    push(0, 16'h123, 1'b1);
    wait_obs(0, 2);
    chk_word(0, 0, "t5_w0", 17'h00023);
    chk_word(0, 1, "t5_w1", 17'h10001);
    @(negedge clk);
    chk("t5_level_end", int'(lv0), 0);

    // Deserialize 4 -> 16
    ordy[1] = 1'b1;
    obs[1].delete();
    push(1, 16'h1, 1'b0);
    push(1, 16'h2, 1'b0);
    push(1, 16'h3, 1'b0);
    push(1, 16'h4, 1'b0);
    @(negedge clk);
    chk("t4_valid", int'(ov[1]), 1);
    chk("t4_data", int'(d1), 'h4321);
    chk("t4_last", int'(ol[1]), 0);
    push(1, 16'h5, 1'b1);
    wait_obs(1, 2);
    chk_word(1, 0, "t4_w0", 17'h04321);
    chk_word(1, 1, "t4_w1", 17'h10005);

    // Randomized traffic on all three configurations
    for (int i = 0; i < 3; i++) cnt[i] = 0;
    cyc = 0;
    while ((cnt[0] < 10000 || cnt[1] < 10000 || cnt[2] < 10000) && cyc < 60000) begin
      @(posedge clk); #1;
      cyc++;
      for (int i = 0; i < 3; i++) begin
        if (iv[i] && macc[i]) begin
          cnt[i]++;
          iv[i] = 1'b0;
          il[i] = 1'b0;
        end
        if (!iv[i] && cnt[i] < 10000 && $urandom_range(3) != 0) begin
          iv[i] = 1'b1;
          idat[i] = 16'($urandom);
          il[i] = (cnt[i] == 9999) || ($urandom_range(63) == 0);
        end
        ordy[i] = ($urandom_range(3) != 0);
      end
    end
    if (cnt[0] < 10000 || cnt[1] < 10000 || cnt[2] < 10000) chk("rand_timeout", cyc, 0);
    iv = '0;
    ordy = 3'b111;
    repeat (40) @(negedge clk);
    chk("rand_level0", int'(lv0), 0);
    chk("rand_level1", int'(lv1), 0);
    chk("rand_level2", int'(lv2), 0);
    for (int i = 0; i < 3; i++) chk($sformatf("u%0d_pop_count", i), dpops[i], mpops[i]);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
